mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage load/store unit between the EX/MEM and MEM/WB pipeline registers. It takes the EX/MEM outputs, runs a request/grant/response handshake with the data memory, and performs byte-lane selection with sign/zero extension. It feeds the MEM/WB register. A `stall` output freezes the upstream pipeline while a memory access is in flight.

## Interface
- `ADDR_W`, 32, byte-address width (data width fixed at 32)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `alu_result_in`  in  ADDR_W  ALU result / effective byte address
- `write_data_in`  in  32  store data
- `rd_in`  in  5, `mem_to_reg_in`  in  2, `reg_write_in`  in  1  WB control, forwarded
- `mem_read_in`, `mem_write_in`  in  1  load / store request
- `size_in`  in  2  00 byte, 01 half, 10 word (11 treated as word)
- `unsigned_in`  in  1  zero-extend loads when 1
- `dmem_req`  out  1, `dmem_we`  out  1, `dmem_addr`  out  ADDR_W (word aligned), `dmem_wdata`  out  32, `dmem_be`  out  4
- `dmem_gnt`  in  1  request accepted
- `dmem_rvalid`  in  1, `dmem_rdata`  in  32  load response
- `stall`  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- `read_data_out`  out  32, `reg_data_out`  out  32, `rd_out`  out  5, `mem_to_reg_out`  out  2, `reg_write_out`  out  1  to MEM/WB
- `misalign_err`  out  1  sticky misalignment flag

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- The access is aligned when: byte always; half needs `addr[0]`=0; word needs `addr[1:0]`=0.
- IDLE, no access: pass-through. `stall`=0, `reg_write_out`=`reg_write_in`.
- IDLE, aligned access:
  - `dmem_req`=1 the same cycle, `stall`=1, `reg_write_out`=0 (bubble into MEM/WB).
  - If `dmem_gnt`=1: store goes to DONE, load goes to WAIT. Otherwise go to REQ.
- IDLE, misaligned access: no request, `stall`=0, `reg_write_out`=0, `misalign_err` set on next edge.
- REQ: `dmem_req` held, `stall`=1, bubble. On `gnt`: store goes to DONE, load goes to WAIT.
- WAIT: `stall`=1, bubble. On `rvalid`: latch `dmem_rdata` into `rdata_q`, go to DONE.
- DONE: `stall`=0, `reg_write_out`=`reg_write_in`, next state IDLE.
- `mem_read_in` and `mem_write_in` both 1: treated as a store.
- `dmem_addr`={addr[ADDR_W-1:2],2'b00}; `dmem_we`=store.
- `dmem_be`: byte 0001<<addr[1:0]; half 0011<<{addr[1],1'b0}; word 1111. The same rule applies to loads.
- `dmem_wdata`: byte {4{wd[7:0]}}, half {2{wd[15:0]}}, word wd.
- `read_data_out`: `rdata_q` lane selected by addr[1:0] and size, then sign- or zero-extended. Driven in all states.
- `reg_data_out`=`alu_result_in`; `rd_out`, `mem_to_reg_out` pass through combinationally.
- EX/MEM inputs are stable while `stall`=1, so the unit does not capture them.
- Ignored inputs: `gnt` outside IDLE/REQ; `rvalid` outside WAIT.

## Timing
- Non-memory instruction: 0 added cycles.
- Store with `gnt` in cycle 0: DONE in cycle 1, one stall cycle.
- Load with `gnt` in cycle 0 and `rvalid` in cycle 1: DONE in cycle 2, two stall cycles.
- Each cycle without `gnt` or `rvalid` adds one stall cycle.
- `rvalid` is accepted no earlier than the cycle after `gnt`.
- Reset, including mid-operation:
  - state goes to IDLE and `rdata_q`=0, so `read_data_out`=0.
  - `misalign_err`=0.
  - In-flight request abandoned; a late `rvalid` is ignored.
- After reset, `dmem_req`, `stall` and the WB outputs follow the IDLE rules for the current inputs. With no access pending, `dmem_req`=0 and `stall`=0.
- Single outstanding access; no pipelined requests.

## Structure
- Package `mem_pkg`:
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`
  - FSM state enum
  - `be_gen` and `wdata_rep` functions
- Sub-module `load_align`: combinational lane select and extension from `rdata_q`, addr[1:0], size and unsigned.

## Test plan
- No memory op, `reg_write_in`=1, `alu_result_in`=0x55 -> `stall`=0, `reg_data_out`=0x55, `reg_write_out`=1 the same cycle.
- Word load @0x104, `gnt` cycle 0, `rvalid` cycle 1 with 0xDEADBEEF:
  - `stall`=1 in cycles 0–1, `reg_write_out`=0 in cycles 0–1.
  - Cycle 2: `read_data_out`=0xDEADBEEF, `reg_write_out`=1.
- Byte load @0x103, rdata 0x80000000 -> `read_data_out` 0xFFFFFF80 when signed; 0x00000080 when `unsigned_in`=1.
- Half store @0x102, data 0x1234ABCD, `gnt` in cycle 3:
  - `dmem_req` held cycles 0–3, `dmem_be`=1100, `dmem_wdata`=0xABCDABCD, `dmem_addr`=0x100.
  - `stall` cycles 0–3, DONE cycle 4.
- Word load @0x101 -> no `dmem_req`, `stall`=0, `reg_write_out`=0, `misalign_err`=1 from the next cycle until `rst`.
- `rst` in WAIT, `rvalid` two cycles later -> IDLE, `dmem_req`=0, `read_data_out`=0, late response ignored.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_e;

  // Byte enables for an access of the given size at byte offset off.
  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: be_gen = 4'b0001 << off;
      SZ_HALF: be_gen = 4'b0011 << {off[1], 1'b0};
      default: be_gen = 4'b1111;
    endcase
  endfunction

  // Replicate store data across all lanes so any enabled lane carries it.
  function automatic logic [31:0] wdata_rep(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      SZ_BYTE: wdata_rep = {4{wd[7:0]}};
      SZ_HALF: wdata_rep = {2{wd[15:0]}};
      default: wdata_rep = wd;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: is_aligned = 1'b1;
      SZ_HALF: is_aligned = ~off[0];
      default: is_aligned = (off == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/grant/response bus between the MEM stage and data memory.
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [3:0]        dmem_be;
  logic              dmem_gnt;
  logic              dmem_rvalid;
  logic [31:0]       dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/load_align.sv
// Selects the addressed lane of a loaded word and sign- or zero-extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data_c
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{off, 3'b000} +: 8];
    half_lane = rdata[{off[1], 4'b0000} +: 16];
    data_c    = rdata;
    case (size)
      SZ_BYTE: data_c = is_unsigned ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      SZ_HALF: data_c = is_unsigned ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
      default: data_c = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: drives the data-memory handshake, stalls upstream
// while an access is in flight and aligns load data for MEM/WB.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] alu_result_in,
  input  logic [31:0]       write_data_in,
  input  logic [4:0]        rd_in,
  input  logic [1:0]        mem_to_reg_in,
  input  logic              reg_write_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [1:0]        size_in,
  input  logic              unsigned_in,
  mem_access_unit_if.master dmem,
  output logic              stall,
  output logic [31:0]       read_data_out,
  output logic [31:0]       reg_data_out,
  output logic [4:0]        rd_out,
  output logic [1:0]        mem_to_reg_out,
  output logic              reg_write_out,
  output logic              misalign_err
);

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misalign_q, misalign_d;

  logic [1:0]  off;
  logic        access;
  logic        is_store;
  logic        aligned;
  logic        req_c;

  assign off      = alu_result_in[1:0];
  assign access   = mem_read_in | mem_write_in;
  assign is_store = mem_write_in;
  assign aligned  = is_aligned(size_in, off);

  // Next-state and handshake outputs; every non-pass-through cycle is a WB bubble.
  always_comb begin
    state_d       = state_q;
    rdata_d       = rdata_q;
    misalign_d    = misalign_q;
    req_c         = 1'b0;
    stall         = 1'b0;
    reg_write_out = reg_write_in;

    unique case (state_q)
      ST_IDLE: begin
        if (access) begin
          reg_write_out = 1'b0;
          if (aligned) begin
            req_c = 1'b1;
            stall = 1'b1;
            if (dmem.dmem_gnt) begin
              state_d = is_store ? ST_DONE : ST_WAIT;
            end else begin
              state_d = ST_REQ;
            end
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        req_c         = 1'b1;
        stall         = 1'b1;
        reg_write_out = 1'b0;
        if (dmem.dmem_gnt) begin
          state_d = is_store ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall         = 1'b1;
        reg_write_out = 1'b0;
        if (dmem.dmem_rvalid) begin
          rdata_d = dmem.dmem_rdata;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rdata_q    <= 32'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

  assign dmem.dmem_req   = req_c;
  assign dmem.dmem_we    = is_store;
  assign dmem.dmem_addr  = {alu_result_in[ADDR_W-1:2], 2'b00};
  assign dmem.dmem_be    = be_gen(size_in, off);
  assign dmem.dmem_wdata = wdata_rep(size_in, write_data_in);

  load_align u_load_align (
    .rdata       (rdata_q),
    .off         (off),
    .size        (size_in),
    .is_unsigned (unsigned_in),
    .data_c      (read_data_out)
  );

  assign reg_data_out   = 32'(alu_result_in);
  assign rd_out         = rd_in;
  assign mem_to_reg_out = mem_to_reg_in;
  assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a read-data scoreboard.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result_in;
  logic [31:0] write_data_in;
  logic [4:0]  rd_in;
  logic [1:0]  mem_to_reg_in;
  logic        reg_write_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [1:0]  size_in;
  logic        unsigned_in;
  logic        stall;
  logic [31:0] read_data_out;
  logic [31:0] reg_data_out;
  logic [4:0]  rd_out;
  logic [1:0]  mem_to_reg_out;
  logic        reg_write_out;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  mem_access_unit_if #(.ADDR_W(32)) dmem_bus ();

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .alu_result_in  (alu_result_in),
    .write_data_in  (write_data_in),
    .rd_in          (rd_in),
    .mem_to_reg_in  (mem_to_reg_in),
    .reg_write_in   (reg_write_in),
    .mem_read_in    (mem_read_in),
    .mem_write_in   (mem_write_in),
    .size_in        (size_in),
    .unsigned_in    (unsigned_in),
    .dmem           (dmem_bus),
    .stall          (stall),
    .read_data_out  (read_data_out),
    .reg_data_out   (reg_data_out),
    .rd_out         (rd_out),
    .mem_to_reg_out (mem_to_reg_out),
    .reg_write_out  (reg_write_out),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    alu_result_in        = 32'h0;
    write_data_in        = 32'h0;
    rd_in                = 5'h0;
    mem_to_reg_in        = 2'b00;
    reg_write_in         = 1'b0;
    mem_read_in          = 1'b0;
    mem_write_in         = 1'b0;
    size_in              = SZ_BYTE;
    unsigned_in          = 1'b0;
    dmem_bus.dmem_gnt    = 1'b0;
    dmem_bus.dmem_rvalid = 1'b0;
    dmem_bus.dmem_rdata  = 32'h0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (dmem_bus.dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", dmem_bus.dmem_req); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", stall); end
    checks++; if (read_data_out !== 32'h0) begin errors++; $display("FAIL reset_rdata got %08h want 00000000", read_data_out); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign got %0b want 0", misalign_err); end
  endtask

  task automatic test_passthrough;
    alu_result_in = 32'h55;
    reg_write_in  = 1'b1;
    rd_in         = 5'd9;
    mem_to_reg_in = 2'b10;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL pass_stall got %0b want 0", stall); end
    checks++; if (reg_data_out !== 32'h55) begin errors++; $display("FAIL pass_regdata got %08h want 00000055", reg_data_out); end
    checks++; if (reg_write_out !== 1'b1) begin errors++; $display("FAIL pass_wb got %0b want 1", reg_write_out); end
    checks++; if (rd_out !== 5'd9 || mem_to_reg_out !== 2'b10) begin errors++; $display("FAIL pass_ctrl got rd %0d m2r %0b want 9 10", rd_out, mem_to_reg_out); end
    checks++; if (dmem_bus.dmem_req !== 1'b0) begin errors++; $display("FAIL pass_req got %0b want 0", dmem_bus.dmem_req); end
    tick();
    clear_inputs();
  endtask

  // One complete access; junk rvalid is driven whenever the unit is not waiting.
  task automatic run_access(input string name, input logic [31:0] addr, input logic [1:0] sz,
                            input logic uns, input logic st, input logic [31:0] wd,
                            input logic [31:0] rdat, input int gnt_dly, input int rv_dly,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_rd);
    int cycle;
    int gcyc;
    int exp_cyc;
    logic granted;
    logic done;
    logic [31:0] exp_addr;
    logic [31:0] popped;
    exp_addr      = {addr[31:2], 2'b00};
    alu_result_in = addr;
    size_in       = sz;
    unsigned_in   = uns;
    mem_write_in  = st;
    mem_read_in   = ~st;
    write_data_in = wd;
    reg_write_in  = ~st;
    rd_in         = 5'd7;
    mem_to_reg_in = 2'b01;
    if (!st) exp_q.push_back(exp_rd);
    cycle   = 0;
    gcyc    = 0;
    granted = 1'b0;
    done    = 1'b0;
    while (!done && cycle < 40) begin
      dmem_bus.dmem_gnt = (!granted && cycle == gnt_dly);
      if (!granted) begin
        dmem_bus.dmem_rvalid = 1'b1;
        dmem_bus.dmem_rdata  = $urandom;
      end else if (!st && cycle == gcyc + 1 + rv_dly) begin
        dmem_bus.dmem_rvalid = 1'b1;
        dmem_bus.dmem_rdata  = rdat;
      end else begin
        dmem_bus.dmem_rvalid = 1'b0;
        dmem_bus.dmem_rdata  = $urandom;
      end
      #1;
      if (cycle == 0) begin
        checks++; if (dmem_bus.dmem_be !== exp_be) begin errors++; $display("FAIL %s_be got %04b want %04b", name, dmem_bus.dmem_be, exp_be); end
        checks++; if (dmem_bus.dmem_addr !== exp_addr) begin errors++; $display("FAIL %s_addr got %08h want %08h", name, dmem_bus.dmem_addr, exp_addr); end
        checks++; if (dmem_bus.dmem_we !== st) begin errors++; $display("FAIL %s_we got %0b want %0b", name, dmem_bus.dmem_we, st); end
        if (st) begin
          checks++; if (dmem_bus.dmem_wdata !== exp_wdata) begin errors++; $display("FAIL %s_wdata got %08h want %08h", name, dmem_bus.dmem_wdata, exp_wdata); end
        end
      end
      if (!stall) begin
        done = 1'b1;
      end else begin
        checks++; if (reg_write_out !== 1'b0) begin errors++; $display("FAIL %s_bubble cyc %0d got %0b want 0", name, cycle, reg_write_out); end
        if (!granted) begin
          checks++; if (dmem_bus.dmem_req !== 1'b1) begin errors++; $display("FAIL %s_req cyc %0d got %0b want 1", name, cycle, dmem_bus.dmem_req); end
        end
      end
      if (dmem_bus.dmem_gnt) begin
        granted = 1'b1;
        gcyc    = cycle;
      end
      if (!done) begin
        tick();
        cycle++;
      end
    end
    dmem_bus.dmem_gnt    = 1'b0;
    dmem_bus.dmem_rvalid = 1'b0;
    exp_cyc = st ? gnt_dly + 1 : gnt_dly + rv_dly + 2;
    checks++; if (!done || cycle != exp_cyc) begin errors++; $display("FAIL %s_latency got done %0b cyc %0d want cyc %0d", name, done, cycle, exp_cyc); end
    if (!st) begin
      popped = exp_q.pop_front();
      if (done) begin
        checks++; if (read_data_out !== popped) begin errors++; $display("FAIL %s_rdata got %08h want %08h", name, read_data_out, popped); end
      end
    end
    if (done) begin
      checks++; if (reg_write_out !== ~st) begin errors++; $display("FAIL %s_done_wb got %0b want %0b", name, reg_write_out, ~st); end
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_loads;
    run_access("wload", 32'h104, SZ_WORD, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF, 0, 0, 4'b1111, 32'h0, 32'hDEADBEEF);
    run_access("bload_s", 32'h103, SZ_BYTE, 1'b0, 1'b0, 32'h0, 32'h80000000, 0, 0, 4'b1000, 32'h0, 32'hFFFFFF80);
    run_access("bload_u", 32'h103, SZ_BYTE, 1'b1, 1'b0, 32'h0, 32'h80000000, 1, 2, 4'b1000, 32'h0, 32'h00000080);
  endtask

  task automatic test_half_store;
    run_access("hstore", 32'h102, SZ_HALF, 1'b0, 1'b1, 32'h1234ABCD, 32'h0, 3, 0, 4'b1100, 32'hABCDABCD, 32'h0);
  endtask

  task automatic test_back_to_back;
    run_access("hload_s", 32'h106, SZ_HALF, 1'b0, 1'b0, 32'h0, 32'h80010000, 2, 3, 4'b1100, 32'h0, 32'hFFFF8001);
    run_access("hload_u", 32'h200, SZ_HALF, 1'b1, 1'b0, 32'h0, 32'h1234F00D, 0, 1, 4'b0011, 32'h0, 32'h0000F00D);
    run_access("bstore", 32'h101, SZ_BYTE, 1'b0, 1'b1, 32'h000000A5, 32'h0, 0, 0, 4'b0010, 32'hA5A5A5A5, 32'h0);
    run_access("wstore11", 32'h108, 2'b11, 1'b0, 1'b1, 32'hCAFEF00D, 32'h0, 1, 0, 4'b1111, 32'hCAFEF00D, 32'h0);
    run_access("both_st", 32'h10C, SZ_WORD, 1'b0, 1'b1, 32'h0BADF00D, 32'h0, 0, 0, 4'b1111, 32'h0BADF00D, 32'h0);
  endtask

  task automatic test_misalign;
    alu_result_in = 32'h101;
    size_in       = SZ_WORD;
    mem_read_in   = 1'b1;
    reg_write_in  = 1'b1;
    #1;
    checks++; if (dmem_bus.dmem_req !== 1'b0) begin errors++; $display("FAIL mis_req got %0b want 0", dmem_bus.dmem_req); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mis_stall got %0b want 0", stall); end
    checks++; if (reg_write_out !== 1'b0) begin errors++; $display("FAIL mis_wb got %0b want 0", reg_write_out); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_early got %0b want 0", misalign_err); end
    tick();
    clear_inputs();
    #1;
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_set got %0b want 1", misalign_err); end
    tick();
    tick();
    tick();
    checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_sticky got %0b want 1", misalign_err); end
  endtask

  task automatic test_reset_in_wait;
    alu_result_in     = 32'h104;
    size_in           = SZ_WORD;
    mem_read_in       = 1'b1;
    reg_write_in      = 1'b1;
    dmem_bus.dmem_gnt = 1'b1;
    #1;
    tick();
    dmem_bus.dmem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rstw_waiting got %0b want 1", stall); end
    tick();
    rst = 1'b0;
    clear_inputs();
    #1;
    checks++; if (dmem_bus.dmem_req !== 1'b0) begin errors++; $display("FAIL rstw_req got %0b want 0", dmem_bus.dmem_req); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstw_stall got %0b want 0", stall); end
    checks++; if (read_data_out !== 32'h0) begin errors++; $display("FAIL rstw_rdata got %08h want 00000000", read_data_out); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL rstw_misalign got %0b want 0", misalign_err); end
    tick();
    dmem_bus.dmem_rvalid = 1'b1;
    dmem_bus.dmem_rdata  = 32'h12345678;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstw_late_stall got %0b want 0", stall); end
    tick();
    dmem_bus.dmem_rvalid = 1'b0;
    dmem_bus.dmem_rdata  = 32'h0;
    size_in              = SZ_WORD;
    #1;
    checks++; if (read_data_out !== 32'h0) begin errors++; $display("FAIL rstw_late_rdata got %08h want 00000000", read_data_out); end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_passthrough();
    test_loads();
    test_half_store();
    test_back_to_back();
    test_misalign();
    test_reset_in_wait();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
